// File: rtl/test_chk_pkg.sv
// Shared encodings for the test_result_checker slice: FSM states,
// per-checkpoint status codes and done_cause codes.
package test_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Per-checkpoint result as reported on res_status
    localparam logic [1:0] STAT_UNTESTED = 2'd0;
    localparam logic [1:0] STAT_PASS     = 2'd1;
    localparam logic [1:0] STAT_FAIL     = 2'd2;
    localparam logic [1:0] STAT_MISSED   = 2'd3;

    // Reason the run finished, as reported on done_cause
    localparam logic [1:0] CAUSE_LAST    = 2'd0;
    localparam logic [1:0] CAUSE_HALT    = 2'd1;
    localparam logic [1:0] CAUSE_FAIL    = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

endpackage

// File: rtl/chk_table.sv
// Checkpoint storage for test_result_checker.
//   clk, reset_n                  : clock, synchronous active-low reset
//   tbl_we/tbl_addr/tbl_num_inst/tbl_ans : checkpoint table write port
//   rd_idx -> rd_num_inst/rd_ans  : asynchronous table read (current pointer)
//   st_clear                      : clears every status entry
//   st_we/st_idx/st_val           : checker status write port
//   res_addr -> res_status        : registered status read (1-cycle latency)
// The table itself has no reset so a loaded program survives reset_n.
module chk_table
    import test_chk_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned NUM_TEST  = 64,
    parameter int unsigned IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tbl_we,
    input  logic [IDX_W-1:0]     tbl_addr,
    input  logic [WORD_SIZE-1:0] tbl_num_inst,
    input  logic [WORD_SIZE-1:0] tbl_ans,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [WORD_SIZE-1:0] rd_num_inst,
    output logic [WORD_SIZE-1:0] rd_ans,
    input  logic                 st_clear,
    input  logic                 st_we,
    input  logic [IDX_W-1:0]     st_idx,
    input  logic [1:0]           st_val,
    input  logic [IDX_W-1:0]     res_addr,
    output logic [1:0]           res_status
);

    logic [2*WORD_SIZE-1:0] mem    [NUM_TEST];
    logic [1:0]             status [NUM_TEST];

    // Table write port; no reset on purpose
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            mem[tbl_addr] <= {tbl_num_inst, tbl_ans};
        end
    end

    assign {rd_num_inst, rd_ans} = mem[rd_idx];

    // Status array: reset and arm both clear it, checker writes one entry per cycle
    always_ff @(posedge clk) begin
        if (!reset_n || st_clear) begin
            for (int i = 0; i < int'(NUM_TEST); i++) begin
                status[i] <= STAT_UNTESTED;
            end
        end else if (st_we) begin
            status[st_idx] <= st_val;
        end
    end

    // Registered status read port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_status <= STAT_UNTESTED;
        end else begin
            res_status <= status[res_addr];
        end
    end

endmodule

// File: rtl/test_result_checker.sv
// Self-checking monitor for a CPU core's debug outputs. Walks a table of
// (instruction count, expected output) checkpoints in order and tallies
// pass / fail / missed entries until the last entry, halt, failure or timeout.
//   clk, reset_n         : clock, synchronous active-low reset
//   tbl_*                : checkpoint table write port (IDLE only)
//   n_tests, arm         : number of valid entries, start/restart pulse
//   num_inst, output_port, is_halted : core debug outputs under test
//   res_addr/res_status  : per-entry status read (1-cycle latency)
//   busy, done, done_cause, pass_all : run state and verdict
//   pass/fail/miss_count, first_fail_idx/val, num_clock : statistics
module test_result_checker
    import test_chk_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned NUM_TEST     = 64,
    parameter int unsigned IDX_W        = 6,
    parameter int unsigned CYC_W        = 16,
    parameter int unsigned MAX_CYCLES   = 10000,
    parameter int unsigned STOP_ON_FAIL = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tbl_we,
    input  logic [IDX_W-1:0]     tbl_addr,
    input  logic [WORD_SIZE-1:0] tbl_num_inst,
    input  logic [WORD_SIZE-1:0] tbl_ans,
    input  logic [IDX_W:0]       n_tests,
    input  logic                 arm,
    input  logic [WORD_SIZE-1:0] num_inst,
    input  logic [WORD_SIZE-1:0] output_port,
    input  logic                 is_halted,
    input  logic [IDX_W-1:0]     res_addr,
    output logic [1:0]           res_status,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           done_cause,
    output logic                 pass_all,
    output logic [IDX_W:0]       pass_count,
    output logic [IDX_W:0]       fail_count,
    output logic [IDX_W:0]       miss_count,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic [WORD_SIZE-1:0] first_fail_val,
    output logic [CYC_W-1:0]     num_clock
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_TEST);
    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0]       n_tests_q, n_tests_nxt;
    logic [CNT_W-1:0]       pass_nxt, fail_nxt, miss_nxt;
    logic [IDX_W-1:0]       ffi_nxt;
    logic [WORD_SIZE-1:0]   ffv_nxt;
    logic [CYC_W-1:0]       nclk_nxt, nclk_inc;
    logic [1:0]             cause_nxt;
    logic                   mismatch;
    logic                   st_clear, st_we;
    logic [1:0]             st_val;
    logic [WORD_SIZE-1:0]   e_num_inst, e_ans;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    chk_table #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_TEST  (NUM_TEST),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk          (clk),
        .reset_n      (reset_n),
        .tbl_we       (tbl_we && (state == ST_IDLE)),
        .tbl_addr     (tbl_addr),
        .tbl_num_inst (tbl_num_inst),
        .tbl_ans      (tbl_ans),
        .rd_idx       (ptr[IDX_W-1:0]),
        .rd_num_inst  (e_num_inst),
        .rd_ans       (e_ans),
        .st_clear     (st_clear),
        .st_we        (st_we),
        .st_idx       (ptr[IDX_W-1:0]),
        .st_val       (st_val),
        .res_addr     (res_addr),
        .res_status   (res_status)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, checkpoint compare and counter updates
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr            <= '0;
            n_tests_q      <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            miss_count     <= '0;
            first_fail_idx <= '0;
            first_fail_val <= '0;
            num_clock      <= '0;
            done_cause     <= CAUSE_LAST;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_all       <= 1'b0;
        end else begin
            ptr            <= ptr_nxt;
            n_tests_q      <= n_tests_nxt;
            pass_count     <= pass_nxt;
            fail_count     <= fail_nxt;
            miss_count     <= miss_nxt;
            first_fail_idx <= ffi_nxt;
            first_fail_val <= ffv_nxt;
            num_clock      <= nclk_nxt;
            done_cause     <= cause_nxt;
            busy           <= (state_nxt == ST_RUN);
            done           <= (state_nxt == ST_DONE);
            pass_all       <= (state_nxt == ST_DONE) && (pass_nxt == n_tests_nxt);
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        n_tests_nxt = n_tests_q;
        pass_nxt    = pass_count;
        fail_nxt    = fail_count;
        miss_nxt    = miss_count;
        ffi_nxt     = first_fail_idx;
        ffv_nxt     = first_fail_val;
        nclk_nxt    = num_clock;
        cause_nxt   = done_cause;
        mismatch    = 1'b0;
        st_clear    = 1'b0;
        st_we       = 1'b0;
        st_val      = STAT_UNTESTED;
        nclk_inc    = (&num_clock) ? num_clock : num_clock + CYC_W'(1);

        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_nxt   = ST_RUN;
                    ptr_nxt     = '0;
                    n_tests_nxt = (n_tests > CNT_MAX) ? CNT_MAX : n_tests;
                    pass_nxt    = '0;
                    fail_nxt    = '0;
                    miss_nxt    = '0;
                    ffi_nxt     = '0;
                    ffv_nxt     = '0;
                    nclk_nxt    = '0;
                    cause_nxt   = CAUSE_LAST;
                    st_clear    = 1'b1;
                end
            end
            ST_RUN: begin
                nclk_nxt = nclk_inc;
                // At most one entry resolves per cycle: exact match checks it,
                // an overshoot marks it missed.
                if (ptr < n_tests_q) begin
                    if (num_inst == e_num_inst) begin
                        st_we   = 1'b1;
                        ptr_nxt = ptr + CNT_W'(1);
                        if (output_port == e_ans) begin
                            st_val   = STAT_PASS;
                            pass_nxt = sat_inc(pass_count);
                        end else begin
                            st_val   = STAT_FAIL;
                            mismatch = 1'b1;
                            fail_nxt = sat_inc(fail_count);
                            if (fail_count == '0) begin
                                ffi_nxt = ptr[IDX_W-1:0];
                                ffv_nxt = output_port;
                            end
                        end
                    end else if (num_inst > e_num_inst) begin
                        st_we    = 1'b1;
                        st_val   = STAT_MISSED;
                        miss_nxt = sat_inc(miss_count);
                        ptr_nxt  = ptr + CNT_W'(1);
                    end
                end

                // Finish conditions in priority order, after this cycle's check
                if ((STOP_ON_FAIL != 0) && mismatch) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_FAIL;
                end else if (is_halted) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_HALT;
                end else if (ptr_nxt >= n_tests_q) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_LAST;
                end else if (nclk_inc == CYC_LIMIT) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
